// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the unified-memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int MAX_OUTSTANDING_DEF = 2;

    typedef enum logic {
        REQ_IMEM = 1'b0,
        REQ_DMEM = 1'b1
    } req_id_t;

    // Count must be able to hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CNT_W_DEF = cnt_width(MAX_OUTSTANDING_DEF);
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory and response signals of the arbiter; slave = arbiter view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
    ;
    logic              imemreq_val, imemreq_rdy;
    logic [ADDR_W-1:0] imemreq_addr;
    logic              imemresp_val;
    logic [DATA_W-1:0] imemresp_data;
    logic              dmemreq_val, dmemreq_rdy, dmemreq_rw;
    logic [ADDR_W-1:0] dmemreq_addr;
    logic [DATA_W-1:0] dmemreq_data;
    logic              dmemresp_val;
    logic [DATA_W-1:0] dmemresp_data;
    logic              memreq_val, memreq_rdy, memreq_rw;
    logic [ADDR_W-1:0] memreq_addr;
    logic [DATA_W-1:0] memreq_data;
    logic              memresp_val;
    logic [DATA_W-1:0] memresp_data;

    modport slave (
        input  imemreq_val, imemreq_addr, dmemreq_val, dmemreq_rw, dmemreq_addr,
               dmemreq_data, memreq_rdy, memresp_val, memresp_data,
        output imemreq_rdy, imemresp_val, imemresp_data, dmemreq_rdy, dmemresp_val,
               dmemresp_data, memreq_val, memreq_rw, memreq_addr, memreq_data
    );
    modport master (
        output imemreq_val, imemreq_addr, dmemreq_val, dmemreq_rw, dmemreq_addr,
               dmemreq_data, memreq_rdy, memresp_val, memresp_data,
        input  imemreq_rdy, imemresp_val, imemresp_data, dmemreq_rdy, dmemresp_val,
               dmemresp_data, memreq_val, memreq_rw, memreq_addr, memreq_data
    );
endinterface

// File: rtl/arb_tag_fifo.sv
// In-order requester-ID FIFO: one bit per outstanding memory transaction.
module arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = cnt_width(DEPTH),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  req_id_t          push_id,
    input  logic             pop,
    output req_id_t          head_id,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [DEPTH-1:0] slot_q, slot_d;
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head_id = req_id_t'(slot_q[rd_q]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        slot_d = slot_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            slot_d[wr_q] = push_id;
            wr_d         = wr_q + PTR_W'(1);
        end
        if (do_pop) rd_d = rd_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            slot_q <= slot_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between imem and dmem; routes in-order responses by tag.
// Define MEM_ARB_RR_EN for round-robin contention; default is fixed dmem priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus,
    output logic          err
);
    localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

    req_id_t          win, lock_id_q, lock_id_d, head_id;
    logic             lock_q, lock_d, err_q, err_d;
    logic             full, empty, xfer, pop, lock_hold;
    logic [CNT_W-1:0] count;
    logic             unused_cnt;
`ifdef MEM_ARB_RR_EN
    req_id_t          last_grant_q, last_grant_d;
`endif

    assign unused_cnt = ^count;
    // A locked requester that drops val loses the lock instead of granting a phantom.
    assign lock_hold  = lock_q && ((lock_id_q == REQ_DMEM) ? bus.dmemreq_val : bus.imemreq_val);

    always_comb begin
        win = REQ_IMEM;
        if (lock_hold)
            win = lock_id_q;
        else if (bus.imemreq_val && bus.dmemreq_val)
`ifdef MEM_ARB_RR_EN
            win = (last_grant_q == REQ_DMEM) ? REQ_IMEM : REQ_DMEM;
`else
            win = REQ_DMEM;
`endif
        else if (bus.dmemreq_val)
            win = REQ_DMEM;
    end

    always_comb begin
        bus.memreq_val  = (bus.imemreq_val || bus.dmemreq_val) && !full && !rst;
        bus.memreq_rw   = (win == REQ_DMEM) ? bus.dmemreq_rw   : 1'b0;
        bus.memreq_addr = (win == REQ_DMEM) ? bus.dmemreq_addr : bus.imemreq_addr;
        bus.memreq_data = (win == REQ_DMEM) ? bus.dmemreq_data : '0;
        bus.imemreq_rdy = bus.memreq_rdy && !full && !rst && (win == REQ_IMEM);
        bus.dmemreq_rdy = bus.memreq_rdy && !full && !rst && (win == REQ_DMEM);
        xfer            = bus.memreq_val && bus.memreq_rdy;
        pop             = bus.memresp_val && !empty && !rst;
        bus.imemresp_val  = pop && (head_id == REQ_IMEM);
        bus.dmemresp_val  = pop && (head_id == REQ_DMEM);
        bus.imemresp_data = bus.memresp_data;
        bus.dmemresp_data = bus.memresp_data;
    end

    always_comb begin
        lock_d    = bus.memreq_val && !bus.memreq_rdy;
        lock_id_d = win;
        err_d     = err_q || (bus.memresp_val && empty);
`ifdef MEM_ARB_RR_EN
        last_grant_d = xfer ? win : last_grant_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= REQ_IMEM;
            err_q     <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= REQ_IMEM;
`endif
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign err = err_q;

    arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tags (
        .clk     (clk),
        .rst     (rst),
        .push    (xfer),
        .push_id (win),
        .pop     (pop),
        .head_id (head_id),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );
endmodule

// File: tb/tb_mem_arbiter.sv
// Random-traffic bench for mem_arbiter with a queue-based reference model and scoreboard.
module tb_mem_arbiter;
    localparam int MAX = 2;

    logic clk = 1'b0;
    logic rst;
    logic err;

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          id;
        logic [31:0] data;
    } resp_t;

    resp_t sb[$];      // expected responses, in delivery order
    bit    tags[$];    // model of outstanding requester IDs (1 = dmem)
    int    n_cmp = 0;
    int    n_bad = 0;

    bit    model_on = 0, lk = 0, lk_id = 0, last_g = 0, i_done = 0, d_done = 0;
    bit    m_iv, m_dv, m_win, m_full, m_val, m_xfer;
    resp_t m_r, mon_r;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: evaluated mid-cycle, when inputs are stable for the coming edge.
    always @(negedge clk) if (model_on) begin
        m_iv   = bus.imemreq_val;
        m_dv   = bus.dmemreq_val;
        m_full = (tags.size() == MAX);
        if (lk && (lk_id ? m_dv : m_iv))
            m_win = lk_id;
        else if (m_iv && m_dv)
`ifdef MEM_ARB_RR_EN
            m_win = !last_g;
`else
            m_win = 1'b1;
`endif
        else
            m_win = m_dv;
        m_val = (m_iv || m_dv) && !m_full;
        chk("memreq_val", bus.memreq_val, m_val);
        if (m_val) begin
            chk("memreq_addr", bus.memreq_addr, m_win ? bus.dmemreq_addr : bus.imemreq_addr);
            chk("memreq_rw", bus.memreq_rw, m_win ? bus.dmemreq_rw : 1'b0);
            if (m_win) chk("memreq_data", bus.memreq_data, bus.dmemreq_data);
        end
        if (m_val || m_full) begin
            chk("imemreq_rdy", bus.imemreq_rdy, m_val && !m_win && bus.memreq_rdy);
            chk("dmemreq_rdy", bus.dmemreq_rdy, m_val && m_win && bus.memreq_rdy);
        end
        m_xfer = m_val && bus.memreq_rdy;
        if (bus.memresp_val && tags.size() > 0) begin
            m_r.id   = tags.pop_front();
            m_r.data = bus.memresp_data;
            sb.push_back(m_r);
        end
        if (m_xfer) begin
            tags.push_back(m_win);
            last_g = m_win;
            if (m_win) d_done = 1; else i_done = 1;
        end
        lk    = m_val && !m_xfer;
        lk_id = m_win;
        chk("err_quiet", err, 1'b0);
    end

    // Monitor: every presented response must match the scoreboard head.
    always @(negedge clk) begin
        #1;
        if (bus.imemresp_val || bus.dmemresp_val || sb.size() > 0) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", {bus.imemresp_val, bus.dmemresp_val}, 32'h0);
            end else begin
                mon_r = sb.pop_front();
                chk("imemresp_val", bus.imemresp_val, !mon_r.id);
                chk("dmemresp_val", bus.dmemresp_val, mon_r.id);
                chk("resp_data", mon_r.id ? bus.dmemresp_data : bus.imemresp_data, mon_r.data);
            end
        end
    end

    task automatic drive(input int p_req, input int p_rdy, input int p_resp);
        @(posedge clk); #1;
        if (!bus.imemreq_val || i_done) begin
            i_done           = 0;
            bus.imemreq_val  = ($urandom_range(0, 99) < p_req);
            bus.imemreq_addr = $urandom;
        end
        if (!bus.dmemreq_val || d_done) begin
            d_done           = 0;
            bus.dmemreq_val  = ($urandom_range(0, 99) < p_req);
            bus.dmemreq_rw   = $urandom_range(0, 1);
            bus.dmemreq_addr = $urandom;
            bus.dmemreq_data = $urandom;
        end
        bus.memreq_rdy   = ($urandom_range(0, 99) < p_rdy);
        bus.memresp_val  = (tags.size() > 0) && ($urandom_range(0, 99) < p_resp);
        bus.memresp_data = $urandom;
    endtask

    initial begin
        int guard;
        rst = 1'b1;
        bus.imemreq_val  = 1'b1; bus.imemreq_addr = 32'h100;
        bus.dmemreq_val  = 1'b1; bus.dmemreq_rw   = 1'b0;
        bus.dmemreq_addr = 32'h200; bus.dmemreq_data = 32'h0;
        bus.memreq_rdy   = 1'b1;
        bus.memresp_val  = 1'b1; bus.memresp_data = 32'hDEADBEEF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_memreq_val", bus.memreq_val, 1'b0);
        chk("rst_imemreq_rdy", bus.imemreq_rdy, 1'b0);
        chk("rst_dmemreq_rdy", bus.dmemreq_rdy, 1'b0);
        chk("rst_imemresp_val", bus.imemresp_val, 1'b0);
        chk("rst_dmemresp_val", bus.dmemresp_val, 1'b0);
        chk("rst_err", err, 1'b0);

        // Response with nothing outstanding: dropped and flagged.
        @(posedge clk); #1;
        rst = 1'b0;
        bus.imemreq_val = 1'b0; bus.dmemreq_val = 1'b0;
        @(negedge clk);
        chk("spur_imemresp_val", bus.imemresp_val, 1'b0);
        chk("spur_dmemresp_val", bus.dmemresp_val, 1'b0);
        @(posedge clk); #1;
        bus.memresp_val = 1'b0;
        @(negedge clk);
        chk("err_set", err, 1'b1);
        @(posedge clk); #1;
        chk("err_sticky", err, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_on = 1;
        @(negedge clk);
        chk("err_cleared", err, 1'b0);

        // Mixed traffic, then a saturating phase to exercise full and lock.
        for (int c = 0; c < 1500; c++) drive(50, 70, 40);
        for (int c = 0; c < 800; c++)  drive(90, 95, 15);
        for (int c = 0; c < 800; c++)  drive(80, 30, 60);

        guard = 0;
        while ((tags.size() > 0 || bus.imemreq_val || bus.dmemreq_val) && guard < 500) begin
            drive(0, 90, 80);
            guard++;
        end
        chk("drain_within_bound", guard < 500, 1'b1);
        repeat (2) @(posedge clk);
        model_on = 0;
        @(negedge clk); #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the processor's single unified memory port between the instruction-fetch requester (imem) and the data-access requester (dmem). It grants one request per cycle and tracks the requester ID of every outstanding transaction in order. Each in-order memory response is routed back to the requester that issued it. It sits between the processor's imemreq/dmemreq ports and the external memory.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered requests; power of two, 2 to 8.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imemreq_val  in  1  fetch request valid.
- imemreq_rdy  out  1  fetch request accepted this cycle when high together with val.
- imemreq_addr  in  32  fetch address.
- imemresp_val  out  1  fetch response valid, one cycle.
- imemresp_data  out  32  fetch response data.
- dmemreq_val  in  1  data request valid.
- dmemreq_rdy  out  1  data request accepted.
- dmemreq_rw  in  1  1 = write, 0 = read.
- dmemreq_addr  in  32  data address.
- dmemreq_data  in  32  write data.
- dmemresp_val  out  1  data response valid; also issued for writes as an ack.
- dmemresp_data  out  32  read data; don't-care for writes.
- memreq_val / memreq_rdy  out / in  1 / 1  unified request handshake.
- memreq_rw, memreq_addr, memreq_data  out  1, 32, 32  muxed request fields; imem always drives rw = 0.
- memresp_val  in  1  memory response valid; memory answers in request order.
- memresp_data  in  32  memory response data.
- err  out  1  sticky protocol-error flag.

## Operation
- Transfer rule: a request transfers when memreq_val && memreq_rdy.
- memreq_val = (imemreq_val || dmemreq_val) && !full && !rst.
- Winner: the requester selected by the grant logic. Only the winner sees rdy: its rdy = memreq_rdy && !full. The loser's rdy is 0.
- Grant lock: if the winner is presented but not transferred (memreq_rdy = 0), lock = 1 and the grant holds that requester until it transfers. This applies even if the other requester would win by priority. The lock clears on transfer.
- Default priority, with no lock active: dmem wins over imem.
- Tag FIFO: on transfer, push the winner ID (0 = imem, 1 = dmem).
- Response routing:
  - On memresp_val with a non-empty FIFO, pop the head.
  - Assert the head's resp_val for that cycle only.
  - Pass memresp_data to both resp_data outputs unchanged.
- Full condition: count == MAX_OUTSTANDING blocks new transfers. A pop in the same cycle does NOT unblock a push; the request is accepted the next cycle.
- Not full: a simultaneous push and pop leaves count unchanged.
- Response on an empty FIFO: the response is dropped, err is set to 1, and count stays at 0. err clears only on rst.
- Requester val dropped while locked: the lock releases and arbitration restarts next cycle. Requesters must not do this; it is not flagged.
- Reset mid-operation: outstanding tags are discarded. Responses arriving after reset are treated as empty-FIFO responses and set err.

## Timing
- Request path is combinational (val/addr to memreq_*) with zero-cycle latency. The grant, lock and count registers update at the clock edge.
- Response path is combinational (memresp_val to imem/dmem resp_val) with zero added latency. The FIFO pops at the edge.
- Reset values:
  - memreq_val = 0, imemreq_rdy = 0, dmemreq_rdy = 0.
  - imemresp_val = 0, dmemresp_val = 0, err = 0.
  - count = 0, lock = 0, last_grant = imem.
- Throughput: one request per cycle and one response per cycle, simultaneously.

## Configuration
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - With both requesters valid and no lock, the requester not in last_grant wins.
  - last_grant updates on every transfer.
  - After reset, dmem wins the first contention.
- MEM_ARB_RR_EN undefined: fixed priority, with dmem always winning contention. The last_grant register is not built.

## Structure
- Package mem_arb_pkg:
  - requester ID type and the constants REQ_IMEM = 0 and REQ_DMEM = 1.
  - ADDR_W = 32 and DATA_W = 32.
  - the count width derived from MAX_OUTSTANDING.
- Sub-module arb_tag_fifo:
  - 1-bit-wide, MAX_OUTSTANDING-deep circular FIFO.
  - Ports: push, push_id, pop, head_id, full, empty, count.
  - Read/write pointers wrap modulo the depth.
- Top level: grant/lock logic, request mux, response demux, err register.

## Test plan
- Single imem read, addr 0x100: memreq_addr = 0x100 with rw = 0. memresp_data 0xDEADBEEF two cycles later → imemresp_val pulses once with 0xDEADBEEF, and dmemresp_val stays 0.
- Both valid with memreq_rdy = 1 every cycle, 4 cycles:
  - MEM_ARB_RR_EN defined → grant order D, I, D, I.
  - Undefined → D, D, D, D, with imemreq_rdy = 0 throughout.
- Grant lock: imem wins, memreq_rdy = 0 for 3 cycles, then dmem raises val → memreq_addr stays on the imem address until transfer, and dmem is granted the next cycle.
- Full: MAX_OUTSTANDING = 2, two transfers with no responses → third request has rdy = 0. Response plus request in the same cycle → the request is accepted next cycle, and count returns to 2.
- Out-of-order ID routing: issue I, D, I and respond with 0x1, 0x2, 0x3 → imem receives 0x1 and 0x3, and dmem receives 0x2, in order.
- Spurious memresp_val after rst → err = 1 from the next cycle, and both resp_val stay 0. Asserting rst clears err.
